seq_event_monitor: RTL and testbench

SEQ_EVENT_MONITOR -- requirements
Module: seq_event_monitor

---
 rtl/seq_event_monitor.sv | 92 +++++++++
 tb/tb_seq_event_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_event_monitor.sv
// seq_event_monitor: counts rising edges of an upstream detector match, with a sticky threshold alarm.
// Gap measurement between events is built only when SEQ_EVENT_MONITOR_GAP_EN is defined.
module seq_event_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic       det,
  input  logic       clr,
  input  logic [7:0] thresh,
  output logic [7:0] count,
  output logic       evt,      // "event" is a reserved word, so the pulse port is named evt
  output logic       alarm,
  output logic [7:0] last_gap
);

  logic       det_q,   det_d;
  logic [7:0] count_q, count_d;
  logic       evt_q,   evt_d;
  logic       alarm_q, alarm_d;
  logic       rise;

  assign rise = det & ~det_q;

  always_comb begin
    det_d   = det;
    count_d = count_q;
    evt_d   = 1'b0;
    alarm_d = alarm_q;
    if (clr) begin
      count_d = 8'd0;
      alarm_d = 1'b0;
    end else begin
      if (rise) begin
        evt_d = 1'b1;
        if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end
      // alarm tracks the updated count, so a lowered thresh can set it without an event
      if ((thresh != 8'd0) && (count_d >= thresh)) alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q   <= 1'b0;
      count_q <= 8'd0;
      evt_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      det_q   <= det_d;
      count_q <= count_d;
      evt_q   <= evt_d;
      alarm_q <= alarm_d;
    end
  end

  assign count = count_q;
  assign evt   = evt_q;
  assign alarm = alarm_q;

`ifdef SEQ_EVENT_MONITOR_GAP_EN
  logic [7:0] gap_q,      gap_d;
  logic [7:0] last_gap_q, last_gap_d;

  always_comb begin
    gap_d      = gap_q;
    last_gap_d = last_gap_q;
    if (clr) begin
      gap_d      = 8'd0;
      last_gap_d = 8'd0;
    end else if (rise) begin
      last_gap_d = gap_q;
      gap_d      = 8'd1;
    end else if (gap_q != 8'hFF) begin
      gap_d = gap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q      <= 8'd0;
      last_gap_q <= 8'd0;
    end else begin
      gap_q      <= gap_d;
      last_gap_q <= last_gap_d;
    end
  end

  assign last_gap = last_gap_q;
`else
  assign last_gap = 8'd0;
`endif

endmodule

// File: tb/tb_seq_event_monitor.sv
// Self-checking bench for seq_event_monitor: directed scenarios plus random stimulus vs a cycle-index model.
module tb_seq_event_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       det = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic [7:0] count;
  logic       evt;
  logic       alarm;
  logic [7:0] last_gap;

  int checks = 0;
  int errors = 0;

  // reference model: event count, sticky alarm, and gap from edge indices
  int m_cyc   = 0;
  int m_count = 0;
  int m_last  = 0;
  int m_ref   = 1;
  bit m_evt   = 1'b0;
  bit m_alarm = 1'b0;
  bit m_prev  = 1'b0;

  seq_event_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .det      (det),
    .clr      (clr),
    .thresh   (thresh),
    .count    (count),
    .evt      (evt),
    .alarm    (alarm),
    .last_gap (last_gap)
  );

  always #5 clk = ~clk;

  task automatic step(input logic d, input logic c, input logic r);
    bit rise;
    det = d;
    clr = c;
    rst = r;
    @(posedge clk);
    m_cyc++;
    if (r) begin
      m_count = 0; m_evt = 0; m_alarm = 0; m_last = 0; m_prev = 0;
      m_ref = m_cyc + 1;
    end else begin
      rise   = d && !m_prev;
      m_prev = d;
      if (c) begin
        m_count = 0; m_evt = 0; m_alarm = 0; m_last = 0;
        m_ref = m_cyc + 1;
      end else begin
        m_evt = rise;
        if (rise) begin
          m_count = (m_count >= 255) ? 255 : m_count + 1;
`ifdef SEQ_EVENT_MONITOR_GAP_EN
          m_last = ((m_cyc - m_ref) > 255) ? 255 : (m_cyc - m_ref);
`endif
          m_ref = m_cyc;
        end
        if (thresh != 8'd0 && m_count >= int'(thresh)) m_alarm = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== 8'd0 || evt !== 1'b0 || alarm !== 1'b0 || last_gap !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got count=%0d evt=%0b alarm=%0b gap=%0d, want all 0",
                 i, count, evt, alarm, last_gap);
      end
    end
  endtask

  task automatic test_gap();
    bit [10:0] pat;
    pat = 11'b100_0000_0001;
    thresh = 8'd0;
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      step(pat[i], 1'b0, 1'b0);
      checks++;
      if (count !== m_count[7:0] || evt !== m_evt || alarm !== m_alarm || last_gap !== m_last[7:0]) begin
        errors++;
        $display("FAIL gap_step[%0d]: got c=%0d e=%0b a=%0b g=%0d want c=%0d e=%0b a=%0b g=%0d",
                 i, count, evt, alarm, last_gap, m_count, m_evt, m_alarm, m_last);
      end
    end
    checks++;
    if (count !== 8'd2 || evt !== 1'b1) begin
      errors++;
      $display("FAIL gap_final_count: got count=%0d evt=%0b want count=2 evt=1", count, evt);
    end
`ifdef SEQ_EVENT_MONITOR_GAP_EN
    checks++;
    if (last_gap !== 8'd10) begin
      errors++;
      $display("FAIL gap_value: got %0d want 10", last_gap);
    end
`endif
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_held_high();
    logic [7:0] c0;
    int pulses;
    c0 = count;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (evt === 1'b1) pulses++;
      checks++;
      if (count !== m_count[7:0] || evt !== m_evt || alarm !== m_alarm || last_gap !== m_last[7:0]) begin
        errors++;
        $display("FAIL held_step[%0d]: got c=%0d e=%0b a=%0b g=%0d want c=%0d e=%0b a=%0b g=%0d",
                 i, count, evt, alarm, last_gap, m_count, m_evt, m_alarm, m_last);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (pulses != 1 || count !== c0 + 8'd1) begin
      errors++;
      $display("FAIL held_single_event: got pulses=%0d count=%0d want pulses=1 count=%0d",
               pulses, count, c0 + 8'd1);
    end
  endtask

  task automatic test_alarm();
    thresh = 8'd3;
    step(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (alarm !== ((p >= 2) ? 1'b1 : 1'b0) || count !== 8'(p + 1)) begin
        errors++;
        $display("FAIL alarm_pulse[%0d]: got alarm=%0b count=%0d want alarm=%0b count=%0d",
                 p, alarm, count, (p >= 2), p + 1);
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (alarm !== 1'b0 || count !== 8'd0 || evt !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clr: got alarm=%0b count=%0d evt=%0b want 0 0 0", alarm, count, evt);
    end
  endtask

  task automatic test_thresh_change();
    thresh = 8'd0;
    step(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    thresh = 8'd10;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (alarm !== 1'b0 || count !== 8'd4) begin
      errors++;
      $display("FAIL thresh_above: got alarm=%0b count=%0d want alarm=0 count=4", alarm, count);
    end
    thresh = 8'd4;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL thresh_lowered: got alarm=%0b want 1", alarm);
    end
    thresh = 8'd200;
    step(1'b0, 1'b0, 1'b0);
    thresh = 8'd0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL thresh_raised_sticky: got alarm=%0b want 1", alarm);
    end
  endtask

  task automatic test_saturation();
    int bad;
    thresh = 8'd0;
    bad = 0;
    step(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 260; p++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (count !== m_count[7:0] || evt !== 1'b1 || last_gap !== m_last[7:0]) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL sat_event[%0d]: got count=%0d evt=%0b gap=%0d want count=%0d evt=1 gap=%0d",
                   p, count, evt, last_gap, m_count, m_last);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (count !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: got count=%0d want 255", count);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 8'd0 || evt !== 1'b0) begin
      errors++;
      $display("FAIL clr_vs_event: got count=%0d evt=%0b want count=0 evt=0", count, evt);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 8'd0 || evt !== 1'b0) begin
      errors++;
      $display("FAIL clr_held_det: got count=%0d evt=%0b want count=0 evt=0", count, evt);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    thresh = 8'd2;
    step(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 5; p++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (count !== 8'd0 || evt !== 1'b0 || alarm !== 1'b0 || last_gap !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got c=%0d e=%0b a=%0b g=%0d want all 0", count, evt, alarm, last_gap);
    end
    thresh = 8'd0;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 8'd1 || evt !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_det: got count=%0d evt=%0b want count=1 evt=1", count, evt);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int bad;
    logic d, c, r;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) thresh = 8'($urandom_range(0, 24));
      d = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 99) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(d, c, r);
      checks++;
      if (count !== m_count[7:0] || evt !== m_evt || alarm !== m_alarm || last_gap !== m_last[7:0]) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL random[%0d]: got c=%0d e=%0b a=%0b g=%0d want c=%0d e=%0b a=%0b g=%0d",
                   i, count, evt, alarm, last_gap, m_count, m_evt, m_alarm, m_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gap();
    test_held_high();
    test_alarm();
    test_thresh_change();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
